spi_flash_rd_seq: RTL

SPI_FLASH_RD_SEQ -- requirements
Module: spi_flash_rd_seq

---
 rtl/spi_flash_rd_seq.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_rd_seq.sv
// SPI flash read sequencer.
// Accepts a (address, length) read request, checks that the range is legal,
// polls the flash status register until the write-in-progress bit clears,
// then issues one fast-read transaction per byte on an x1 SPI engine and
// returns every byte with a one-cycle strobe. It ends with o_done or o_err.
module spi_flash_rd_seq #(
    parameter logic [7:0]  CMD_RDSR = 8'h05,
    parameter logic [7:0]  CMD_READ = 8'h0B,
    parameter logic [2:0]  RD_DUMMY = 3'd1,
    parameter int unsigned POLL_MAX = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [23:0] i_req_addr,
    input  logic [7:0]  i_req_len,
    output logic        o_busy,
    output logic [7:0]  o_rd_data,
    output logic        o_rd_vld,
    output logic        o_done,
    output logic        o_err,
    output logic        o_spi_start,
    output logic [7:0]  o_spi_cmd,
    output logic [23:0] o_spi_addr,
    output logic [2:0]  o_spi_dum_num,
    output logic        o_spi_exi_rdata,
    input  logic        i_spi_rdy,
    input  logic        i_spi_finish,
    input  logic [7:0]  i_spi_data
);

    // Poll counter must be able to hold POLL_MAX itself.
    localparam int unsigned PCW = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CHECK      = 3'd1,
        S_POLL_ISSUE = 3'd2,
        S_POLL_WAIT  = 3'd3,
        S_READ_ISSUE = 3'd4,
        S_READ_WAIT  = 3'd5,
        S_DONE       = 3'd6,
        S_ERR        = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [23:0]      cur_addr_q, cur_addr_d;
    logic [7:0]       rem_len_q, rem_len_d;
    logic [PCW-1:0]   poll_cnt_q, poll_cnt_d;
    logic             busy_q, busy_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_vld_q, rd_vld_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             spi_start_q, spi_start_d;
    logic [7:0]       spi_cmd_q, spi_cmd_d;
    logic [23:0]      spi_addr_q, spi_addr_d;
    logic [2:0]       spi_dum_q, spi_dum_d;
    logic             spi_exi_q, spi_exi_d;

    logic [24:0]      end_addr_s;
    logic [PCW-1:0]   poll_inc_s;

    // Last byte address of the request, kept 25 bits wide so a range that
    // runs past the top of the 24-bit space shows up as a carry.
    assign end_addr_s = {1'b0, cur_addr_q} + {17'd0, rem_len_q} - 25'd1;
    assign poll_inc_s = poll_cnt_q + PCW'(1);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_len_d   = rem_len_q;
        poll_cnt_d  = poll_cnt_q;
        rd_data_d   = rd_data_q;
        rd_vld_d    = 1'b0;
        spi_start_d = 1'b0;
        spi_cmd_d   = spi_cmd_q;
        spi_addr_d  = spi_addr_q;
        spi_dum_d   = spi_dum_q;
        spi_exi_d   = spi_exi_q;

        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    cur_addr_d = i_req_addr;
                    rem_len_d  = i_req_len;
                    poll_cnt_d = '0;
                    state_d    = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (rem_len_q == 8'd0) begin
                    state_d = S_DONE;
                end else if (cur_addr_q == 24'd0) begin
                    // The engine reads address 0 as "no address phase".
                    state_d = S_ERR;
                end else if (end_addr_s > 25'h0FF_FFFF) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_POLL_ISSUE;
                end
            end
            S_POLL_ISSUE: begin
                if (i_spi_rdy) begin
                    spi_start_d = 1'b1;
                    spi_cmd_d   = CMD_RDSR;
                    spi_addr_d  = 24'd0;
                    spi_dum_d   = 3'd0;
                    spi_exi_d   = 1'b1;
                    state_d     = S_POLL_WAIT;
                end else begin
                    state_d = S_POLL_ISSUE;
                end
            end
            S_POLL_WAIT: begin
                if (i_spi_finish) begin
                    if (i_spi_data[0] == 1'b0) begin
                        state_d = S_READ_ISSUE;
                    end else begin
                        poll_cnt_d = poll_inc_s;
                        if (poll_inc_s == PCW'(POLL_MAX)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_POLL_ISSUE;
                        end
                    end
                end else begin
                    state_d = S_POLL_WAIT;
                end
            end
            S_READ_ISSUE: begin
                if (i_spi_rdy) begin
                    spi_start_d = 1'b1;
                    spi_cmd_d   = CMD_READ;
                    spi_addr_d  = cur_addr_q;
                    spi_dum_d   = RD_DUMMY;
                    spi_exi_d   = 1'b1;
                    state_d     = S_READ_WAIT;
                end else begin
                    state_d = S_READ_ISSUE;
                end
            end
            S_READ_WAIT: begin
                if (i_spi_finish) begin
                    rd_data_d  = i_spi_data;
                    rd_vld_d   = 1'b1;
                    cur_addr_d = cur_addr_q + 24'd1;
                    rem_len_d  = rem_len_q - 8'd1;
                    if (rem_len_q == 8'd1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ_ISSUE;
                    end
                end else begin
                    state_d = S_READ_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs follow the state being entered so they are registered.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    // State and datapath registers; reset aborts any transaction silently.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= 24'd0;
            rem_len_q   <= 8'd0;
            poll_cnt_q  <= '0;
            busy_q      <= 1'b0;
            rd_data_q   <= 8'd0;
            rd_vld_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            spi_start_q <= 1'b0;
            spi_cmd_q   <= 8'd0;
            spi_addr_q  <= 24'd0;
            spi_dum_q   <= 3'd0;
            spi_exi_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_len_q   <= rem_len_d;
            poll_cnt_q  <= poll_cnt_d;
            busy_q      <= busy_d;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_vld_d;
            done_q      <= done_d;
            err_q       <= err_d;
            spi_start_q <= spi_start_d;
            spi_cmd_q   <= spi_cmd_d;
            spi_addr_q  <= spi_addr_d;
            spi_dum_q   <= spi_dum_d;
            spi_exi_q   <= spi_exi_d;
        end
    end

    assign o_busy          = busy_q;
    assign o_rd_data       = rd_data_q;
    assign o_rd_vld        = rd_vld_q;
    assign o_done          = done_q;
    assign o_err           = err_q;
    assign o_spi_start     = spi_start_q;
    assign o_spi_cmd       = spi_cmd_q;
    assign o_spi_addr      = spi_addr_q;
    assign o_spi_dum_num   = spi_dum_q;
    assign o_spi_exi_rdata = spi_exi_q;

endmodule
